// File: rtl/branch_outcome_checker.sv
// branch_outcome_checker: in-order prediction queue checked against resolved outcomes, flush on mispredict, saturating accuracy counters, windowed miss report; BRANCH_STREAK_EN adds max_streak
module branch_outcome_checker #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic [TAG_W-1:0]           pred_tag,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       flush,
  output logic [TAG_W-1:0]           flush_tag,
  output logic [CNT_W-1:0]           total_cnt,
  output logic [CNT_W-1:0]           miss_cnt,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [CNT_W-1:0]           window_miss,
  output logic                       window_done,
  output logic                       underflow_err,
`ifdef BRANCH_STREAK_EN
  output logic [CNT_W-1:0]           max_streak,
`endif
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic {COUNT, REPORT} state_t;
  state_t state;
  logic [TAG_W:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] win_cnt, win_acc, wc_next, acc_next;
  logic [OW-1:0] occ_next;
  logic push, pop, miss, wrap;
  always_comb begin
    push = pred_valid && pred_ready;
    pop = res_valid && occupancy != '0;
    miss = mem[rd_ptr][TAG_W] != res_taken;
    occ_next = occupancy + OW'(push) - OW'(pop);
    wc_next = win_cnt + 1'b1;
    acc_next = win_acc + CNT_W'(miss);
    wrap = wc_next == CNT_W'(WINDOW);
  end
  assign window_done = state == REPORT;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {pred_taken, pred_tag};
`ifdef BRANCH_STREAK_EN
  logic [CNT_W-1:0] run, run_next;
  always_comb run_next = miss ? run + CNT_W'(run != CMAX) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      run <= '0;
      max_streak <= '0;
    end else if (pop) begin
      run <= run_next;
      max_streak <= run_next > max_streak ? run_next : max_streak;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COUNT;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
      pred_ready <= 1'b0;
      flush <= 1'b0;
      flush_tag <= '0;
      total_cnt <= '0;
      miss_cnt <= '0;
      hit_cnt <= '0;
      window_miss <= '0;
      underflow_err <= 1'b0;
      win_cnt <= '0;
      win_acc <= '0;
    end else begin
      occupancy <= occ_next;
      pred_ready <= occ_next != OW'(DEPTH);
      flush <= pop && miss;
      state <= pop && wrap ? REPORT : COUNT;
      if (res_valid && occupancy == '0) underflow_err <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        total_cnt <= total_cnt + CNT_W'(total_cnt != CMAX);
        miss_cnt <= miss_cnt + CNT_W'(miss && miss_cnt != CMAX);
        hit_cnt <= hit_cnt + CNT_W'(!miss && hit_cnt != CMAX);
        if (miss) flush_tag <= mem[rd_ptr][TAG_W-1:0];
        win_cnt <= wrap ? '0 : wc_next;
        win_acc <= wrap ? '0 : acc_next;
        if (wrap) window_miss <= acc_next;
      end
    end
  end
endmodule

// File: tb/tb_branch_outcome_checker.sv
// tb_branch_outcome_checker: directed stimulus with flush/window scoreboards for branch_outcome_checker
module tb_branch_outcome_checker;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int CNT_W = 3;
  localparam int WINDOW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [TAG_W-1:0] pred_tag = '0;
  logic pred_ready, flush, window_done, underflow_err;
  logic [TAG_W-1:0] flush_tag;
  logic [CNT_W-1:0] total_cnt, miss_cnt, hit_cnt, window_miss;
  logic [$clog2(DEPTH):0] occupancy;
`ifdef BRANCH_STREAK_EN
  logic [CNT_W-1:0] max_streak;
`endif
  int checks = 0;
  int fails = 0;
  logic [TAG_W-1:0] fq[$];
  logic [CNT_W-1:0] wq[$];
  logic [TAG_W-1:0] e_tag;
  logic [CNT_W-1:0] e_win;
  logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  branch_outcome_checker #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_tag(pred_tag), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .flush(flush), .flush_tag(flush_tag),
    .total_cnt(total_cnt), .miss_cnt(miss_cnt), .hit_cnt(hit_cnt),
    .window_miss(window_miss), .window_done(window_done), .underflow_err(underflow_err),
`ifdef BRANCH_STREAK_EN
    .max_streak(max_streak),
`endif
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (flush) begin
      checks++;
      if (fq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_flush got tag=%0d expected no flush", flush_tag);
      end else begin
        e_tag = fq.pop_front();
        if (flush_tag !== e_tag) begin
          fails++;
          $display("FAIL flush_tag got=%0d expected=%0d", flush_tag, e_tag);
        end
      end
    end
    if (window_done) begin
      checks++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_window_done got window_miss=%0d", window_miss);
      end else begin
        e_win = wq.pop_front();
        if (window_miss !== e_win) begin
          fails++;
          $display("FAIL window_miss got=%0d expected=%0d", window_miss, e_win);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic step(input logic pv, input logic pt, input logic [TAG_W-1:0] ptag, input logic rv, input logic rt);
    pred_valid = pv;
    pred_taken = pt;
    pred_tag = ptag;
    res_valid = rv;
    res_taken = rt;
    tick();
    pred_valid = 1'b0;
    res_valid = 1'b0;
  endtask
  task automatic push(input logic t, input logic [TAG_W-1:0] tag);
    step(1'b1, t, tag, 1'b0, 1'b0);
  endtask
  task automatic res(input logic t);
    step(1'b0, 1'b0, '0, 1'b1, t);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
  task automatic settle(input string name);
    tick();
    tick();
    chk({name, "_flush_q_empty"}, fq.size(), 0);
    chk({name, "_window_q_empty"}, wq.size(), 0);
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_occ", occupancy, 0);
    chk("rst_total", total_cnt, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_flush", flush, 0);
    chk("rst_underflow", underflow_err, 0);
    chk("rst_ready_low", pred_ready, 0);
    tick();
    chk("ready_after_reset", pred_ready, 1);
    // basic: T,N,T resolved T,T,T; third push overlaps first resolution
    push(1'b1, 4'd1);
    push(1'b0, 4'd2);
    fq.push_back(4'd2);
    step(1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
    chk("simul_occ", occupancy, 2);
    res(1'b1);
    res(1'b1);
    settle("basic");
    chk("basic_total", total_cnt, 3);
    chk("basic_hit", hit_cnt, 2);
    chk("basic_miss", miss_cnt, 1);
    chk("basic_occ", occupancy, 0);
    // full queue: 9th dropped, pop while full, refill
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 4'(i), 1'b0, 1'b0);
    chk("full_occ", occupancy, 8);
    chk("full_ready", pred_ready, 0);
    step(1'b1, 1'b0, 4'd9, 1'b1, 1'b1);
    chk("pop_full_occ", occupancy, 7);
    chk("pop_full_ready", pred_ready, 1);
    step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
    chk("refill_occ", occupancy, 8);
    chk("refill_ready", pred_ready, 0);
    wq.push_back(3'd0);
    wq.push_back(3'd0);
    fq.push_back(4'd9);
    for (int i = 0; i < 8; i++) res(1'b1);
    settle("full");
    chk("full_total_sat", total_cnt, 7);
    chk("full_hit_sat", hit_cnt, 7);
    chk("full_miss", miss_cnt, 1);
    chk("full_occ_end", occupancy, 0);
    // underflow with same-cycle push: no bypass
    do_reset();
    step(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    chk("uf_err", underflow_err, 1);
    chk("uf_total", total_cnt, 0);
    chk("uf_occ", occupancy, 1);
    fq.push_back(4'd5);
    res(1'b0);
    settle("uf");
    chk("uf_sticky", underflow_err, 1);
    chk("uf_total_after", total_cnt, 1);
    chk("uf_miss_after", miss_cnt, 1);
    // windows of 4 with misses on #2, #4, #5
    do_reset();
    for (int i = 0; i < 8; i++) push(1'b1, 4'(i));
    fq.push_back(4'd1);
    fq.push_back(4'd3);
    fq.push_back(4'd4);
    wq.push_back(3'd2);
    wq.push_back(3'd1);
    for (int i = 0; i < 8; i++) res(pat[i]);
    settle("win");
    chk("win_miss_cnt", miss_cnt, 3);
    chk("win_hit_cnt", hit_cnt, 5);
    chk("win_total_sat", total_cnt, 7);
    // saturation: 10 mispredicts, then hit, miss, miss
    do_reset();
    wq.push_back(3'd4);
    wq.push_back(3'd4);
    wq.push_back(3'd3);
    for (int i = 0; i < 10; i++) begin
      push(1'b1, 4'(i));
      fq.push_back(4'(i));
      res(1'b0);
    end
    tick();
    tick();
    chk("sat_miss", miss_cnt, 7);
    chk("sat_total", total_cnt, 7);
    chk("sat_hit", hit_cnt, 0);
`ifdef BRANCH_STREAK_EN
    chk("sat_streak", max_streak, 7);
`endif
    push(1'b1, 4'd10);
    res(1'b1);
    push(1'b1, 4'd11);
    fq.push_back(4'd11);
    res(1'b0);
    push(1'b1, 4'd12);
    fq.push_back(4'd12);
    res(1'b0);
    settle("sat");
    chk("sat_hit_after", hit_cnt, 1);
    chk("sat_miss_after", miss_cnt, 7);
`ifdef BRANCH_STREAK_EN
    chk("streak_kept", max_streak, 7);
`endif
    // reset mid-operation with 5 entries in flight
    do_reset();
    for (int i = 0; i < 6; i++) push(1'b1, 4'(i));
    fq.push_back(4'd0);
    res(1'b0);
    tick();
    chk("inflight_occ", occupancy, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_total", total_cnt, 0);
    chk("mid_rst_miss", miss_cnt, 0);
    chk("mid_rst_hit", hit_cnt, 0);
    chk("mid_rst_flush", flush, 0);
    tick();
    res(1'b1);
    chk("mid_rst_uf", underflow_err, 1);
    chk("mid_rst_uf_total", total_cnt, 0);
    settle("midrst");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
